decode_exec_pipe_stage: RTL and testbench
=========================================

Name: decode_exec_pipe_stage

Overview:
Parametrised decode-to-execute pipeline stage register for the RISC-V pipeline. It carries a control bundle and N data words between stages over a valid/ready handshake. A 2-entry skid buffer keeps ready_o registered. Synchronous flush inserts a bubble, and a saturating counter reports bubble cycles for performance analysis.

Parameters:
DATA_WIDTH, 32, width of each data word (PC, RD1, RD2, ImmExt, ...)
NUM_DATA, 4, number of data words carried
CTRL_WIDTH, 12, width of packed control bundle (resultSrc, memWrite, branch, ALUCtrl[3:0], JAL, JALR, ...)
CNT_WIDTH, 16, width of bubble counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  upstream (decode) payload valid
ready_o  out  1  stage can accept; registered
ctrl_i  in  CTRL_WIDTH  decode control bundle
data_i  in  NUM_DATA*DATA_WIDTH  decode data words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
flush_i  in  1  synchronous flush from branch/jump resolution
valid_o  out  1  execute payload valid
ready_i  in  1  execute stage can accept
ctrl_o  out  CTRL_WIDTH  execute control; forced to 0 when valid_o=0
data_o  out  NUM_DATA*DATA_WIDTH  execute data words
bubble_cnt_o  out  CNT_WIDTH  saturating count of cycles with valid_o=0

Behaviour:
- Reset, async on rst_n low:
  - main and skid entries empty; stored ctrl/data = 0.
  - valid_o=0, ctrl_o=0, data_o=0, ready_o=1, bubble_cnt_o=0.
  - Reset mid-transfer discards all held payloads.
- State, encoded by entry occupancy: EMPTY (main empty), ONE (main full, skid empty), TWO (main and skid full).
  - valid_o = main full.
  - ready_o is a register, equal to 1 in EMPTY and ONE and 0 in TWO.
- Definitions: accept = valid_i & ready_o; pop = valid_o & ready_i.
- Transitions (flush_i=0):
  - EMPTY: accept -> main<=input, ONE.
  - ONE:
    - pop & accept -> main<=input, stay ONE.
    - pop only -> EMPTY.
    - accept only -> skid<=input, TWO.
    - neither -> hold.
  - TWO:
    - pop -> main<=skid, skid empty, ONE. ready_o=0 in TWO, so no accept occurs.
    - no pop -> hold.
- Latency: one cycle from accept into EMPTY to valid_o. Throughput is 1 payload/cycle when ready_i stays 1.
- Ordering is strictly FIFO; no payload is duplicated or dropped except by flush.
- Flush: flush_i=1 on a rising edge.
  - Both entries go empty; state becomes EMPTY; ready_o<=1; stored ctrl is zeroed.
  - flush_i has priority over accept and pop. Input presented in the flush cycle is discarded even if ready_o=1.
  - A pop in the flush cycle still completes downstream; the stage does not re-present that payload.
- Bubble output: whenever valid_o=0, ctrl_o=0 so memWrite/branch/JAL are inactive. data_o keeps its last stored value when valid_o=0.
- Counter: bubble_cnt_o increments on each rising edge where valid_o=0 and saturates at all-ones. It is cleared only by reset.
- Stalls from the hazard unit arrive as ready_i=0. The held payload must remain bit-stable on ctrl_o/data_o while valid_o=1 and ready_i=0.

Decomposition:
- Package riscv_pipe_pkg:
  - ctrl_bundle_t packed struct, whose width sets CTRL_WIDTH.
  - ALU control encoding constants.
  - Stage-state enum {ST_EMPTY, ST_ONE, ST_TWO}.
- Sub-module pipe_skid_entry: one payload register with load/clear controls and a full flag. Instantiate it twice (main, skid); the top holds the FSM, the flush logic and the counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while valid_i=1 and ctrl_i=12'hFFF -> valid_o=0, ctrl_o=0, ready_o=1, bubble_cnt_o=0 throughout; release with ready_i=1 and first payload 32'h0000_0004 -> valid_o=1 one cycle later.
- Streaming: ready_i=1, feed payloads with PC words 0,4,8,...,0x3C over 16 consecutive cycles -> same sequence appears on data_o one cycle delayed, valid_o high for 16 cycles, ready_o never deasserts.
- Backpressure: ready_i=0 while feeding PC 0x10, 0x14, 0x18 -> state TWO after 2 accepts; ready_o=0; 0x18 held upstream. Raise ready_i -> outputs 0x10, 0x14, 0x18 in order with no loss.
- Flush in TWO: fill both entries, assert flush_i with valid_i=1 (PC 0x40) for one cycle -> next cycle valid_o=0, ctrl_o=0, ready_o=1, and 0x40 never appears on the output.
- Flush and pop together: state ONE, ready_i=1, flush_i=1 -> current payload popped once, stage EMPTY next cycle, no duplicate.
- Counter saturation with CNT_WIDTH=4: idle 20 cycles after reset -> bubble_cnt_o stops at 4'hF; a valid payload does not decrement it.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RISC-V pipeline: decode control bundle, ALU encodings
// and the decode->execute stage state.
package riscv_pipe_pkg;

    // ALU operation encodings carried in ctrl_bundle_t.alu_ctrl
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1010;

    typedef struct packed {
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic [3:0] alu_ctrl;
        logic       jal;
        logic       jalr;
        logic       alu_src;
        logic       reg_write;
    } ctrl_bundle_t;

    localparam int unsigned CTRL_BUNDLE_W = $bits(ctrl_bundle_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload slot of the decode->execute stage: control + data words and a full flag.
// Clearing zeroes the control (so an empty slot never looks like a live op) but keeps data.
module pipe_skid_entry #(
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q,
    output logic              full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full   <= 1'b0;
            ctrl_q <= '0;
            data_q <= '0;
        end else if (clear) begin
            full   <= 1'b0;
            ctrl_q <= '0;
        end else if (load) begin
            full   <= 1'b1;
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/decode_exec_pipe_stage.sv
// Decode->execute pipeline register with a 2-entry skid buffer (registered ready_o),
// synchronous flush and a saturating bubble-cycle counter.
module decode_exec_pipe_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_DATA   = 4,
    parameter int unsigned CTRL_WIDTH = CTRL_BUNDLE_W,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [CTRL_WIDTH-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
    input  logic                           flush_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [CTRL_WIDTH-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_WIDTH-1:0] data_o,
    output logic [CNT_WIDTH-1:0]           bubble_cnt_o
);

    localparam int unsigned BUS_W = NUM_DATA * DATA_WIDTH;

    stage_state_t state, state_nxt;

    logic                  accept, pop;
    logic                  main_load, main_clr, main_sel_skid;
    logic                  skid_load, skid_clr;
    logic                  main_full, skid_full;
    logic [CTRL_WIDTH-1:0] main_ctrl_d, skid_ctrl;
    logic [BUS_W-1:0]      main_data_d, skid_data;

    assign accept = valid_i & ready_o;
    assign pop    = valid_o & ready_i;

    assign main_ctrl_d = main_sel_skid ? skid_ctrl : ctrl_i;
    assign main_data_d = main_sel_skid ? skid_data : data_i;

    // State register; ready_o is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_EMPTY;
            ready_o <= 1'b1;
        end else begin
            state   <= state_nxt;
            ready_o <= (state_nxt != ST_TWO);
        end
    end

    // Next-state and entry controls; flush overrides accept and pop
    always_comb begin
        state_nxt     = state;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_sel_skid = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        if (flush_i) begin
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
            state_nxt = ST_EMPTY;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (pop && accept) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        // Clearing zeroes stored ctrl so the bubble is inert
                        main_clr  = 1'b1;
                        state_nxt = ST_EMPTY;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (pop && skid_full) begin
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                        skid_clr      = 1'b1;
                        state_nxt     = ST_ONE;
                    end
                end
                default: begin
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_skid_entry #(
        .CTRL_W (CTRL_WIDTH),
        .DATA_W (BUS_W)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (main_load),
        .clear  (main_clr),
        .ctrl_d (main_ctrl_d),
        .data_d (main_data_d),
        .ctrl_q (ctrl_o),
        .data_q (data_o),
        .full   (main_full)
    );

    pipe_skid_entry #(
        .CTRL_W (CTRL_WIDTH),
        .DATA_W (BUS_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .clear  (skid_clr),
        .ctrl_d (ctrl_i),
        .data_d (data_i),
        .ctrl_q (skid_ctrl),
        .data_q (skid_data),
        .full   (skid_full)
    );

    assign valid_o = main_full;

    // Saturating count of edges seen with no valid payload at the output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_o <= '0;
        end else if (!valid_o && (bubble_cnt_o != {CNT_WIDTH{1'b1}})) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_decode_exec_pipe_stage.sv
// Directed self-checking bench for decode_exec_pipe_stage (bubble counter built 4 bits wide
// so saturation is reachable quickly).
module tb_decode_exec_pipe_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned ND = 4;
    localparam int unsigned CW = 12;
    localparam int unsigned KW = 4;

    logic            clk;
    logic            rst_n;
    logic            valid_i;
    logic            ready_o;
    logic [CW-1:0]   ctrl_i;
    logic [ND*DW-1:0] data_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [CW-1:0]   ctrl_o;
    logic [ND*DW-1:0] data_o;
    logic [KW-1:0]   bubble_cnt_o;

    int total = 0;
    int bad   = 0;

    decode_exec_pipe_stage #(
        .DATA_WIDTH (DW),
        .NUM_DATA   (ND),
        .CTRL_WIDTH (CW),
        .CNT_WIDTH  (KW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .ctrl_i       (ctrl_i),
        .data_i       (data_i),
        .flush_i      (flush_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .ctrl_o       (ctrl_o),
        .data_o       (data_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] ctl_of(input logic [31:0] pc);
        return CW'(pc) ^ 12'hA5A;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        valid_i = v;
        ctrl_i  = ctl_of(pc);
        data_i  = {pc + 32'd3, pc + 32'd2, pc + 32'd1, pc};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check a live payload on the output: valid, PC word, top word and ctrl
    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, 64'(valid_o), 64'd1);
        chk({tag, ".pc"}, 64'(data_o[DW-1:0]), 64'(pc));
        chk({tag, ".w3"}, 64'(data_o[ND*DW-1 -: DW]), 64'(pc + 32'd3));
        chk({tag, ".ctrl"}, 64'(ctrl_o), 64'(ctl_of(pc)));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 64'(valid_o), 64'd0);
        chk({tag, ".ctrl"}, 64'(ctrl_o), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b1;
        valid_i = 1'b1;
        ctrl_i  = 12'hFFF;
        data_i  = '1;

        // Reset held with garbage presented
        for (int i = 0; i < 3; i++) begin
            step();
            chk_bubble("rst");
            chk("rst.ready", 64'(ready_o), 64'd1);
            chk("rst.cnt", 64'(bubble_cnt_o), 64'd0);
            chk("rst.data", 64'(data_o[DW-1:0]), 64'd0);
        end

        // Idle after reset: counter climbs and saturates at 4'hF
        rst_n = 1'b1;
        drive(1'b0, 32'h0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("sat.cnt", 64'(bubble_cnt_o), (i < 15) ? 64'(i) : 64'hF);
            chk("sat.valid", 64'(valid_o), 64'd0);
        end

        // First payload: one cycle latency; counter does not move backwards
        drive(1'b1, 32'h4);
        step();
        chk_out("first", 32'h4);
        chk("first.cnt", 64'(bubble_cnt_o), 64'hF);
        drive(1'b0, 32'h0);
        step();
        chk_bubble("first.drain");
        chk("first.hold", 64'(data_o[DW-1:0]), 64'h4);

        // Streaming at full rate
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(4 * i));
            step();
            chk_out("stream", 32'(4 * i));
            chk("stream.ready", 64'(ready_o), 64'd1);
        end
        drive(1'b0, 32'h0);
        step();
        chk_bubble("stream.end");
        chk("stream.hold", 64'(data_o[DW-1:0]), 64'h3C);

        // Backpressure fills skid, then drains in order
        ready_i = 1'b0;
        drive(1'b1, 32'h10);
        step();
        chk_out("bp.one", 32'h10);
        chk("bp.one.ready", 64'(ready_o), 64'd1);
        drive(1'b1, 32'h14);
        step();
        chk_out("bp.two", 32'h10);
        chk("bp.two.ready", 64'(ready_o), 64'd0);
        drive(1'b1, 32'h18);
        step();
        chk_out("bp.stall", 32'h10);
        chk("bp.stall.ready", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        step();
        chk_out("bp.d14", 32'h14);
        chk("bp.d14.ready", 64'(ready_o), 64'd1);
        step();
        chk_out("bp.d18", 32'h18);
        drive(1'b0, 32'h0);
        step();
        chk_bubble("bp.empty");

        // Flush with both entries full and input presented
        ready_i = 1'b0;
        drive(1'b1, 32'h20);
        step();
        drive(1'b1, 32'h24);
        step();
        chk("fl2.ready_pre", 64'(ready_o), 64'd0);
        flush_i = 1'b1;
        drive(1'b1, 32'h40);
        step();
        flush_i = 1'b0;
        chk_bubble("fl2");
        chk("fl2.ready", 64'(ready_o), 64'd1);
        chk("fl2.data", 64'(data_o[DW-1:0]), 64'h20);
        drive(1'b0, 32'h0);
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_bubble("fl2.after");
            chk("fl2.after.data", 64'(data_o[DW-1:0]), 64'h20);
        end

        // Flush coinciding with a pop in ONE
        drive(1'b1, 32'h50);
        step();
        chk_out("flpop.one", 32'h50);
        flush_i = 1'b1;
        drive(1'b1, 32'h54);
        step();
        flush_i = 1'b0;
        drive(1'b0, 32'h0);
        chk_bubble("flpop");
        chk("flpop.ready", 64'(ready_o), 64'd1);
        step();
        chk_bubble("flpop.nodup");

        // Asynchronous reset mid-transfer drops held payloads
        ready_i = 1'b0;
        drive(1'b1, 32'h60);
        step();
        drive(1'b1, 32'h64);
        step();
        chk_out("arst.pre", 32'h60);
        rst_n = 1'b0;
        #1;
        chk_bubble("arst");
        chk("arst.ready", 64'(ready_o), 64'd1);
        chk("arst.cnt", 64'(bubble_cnt_o), 64'd0);
        chk("arst.data", 64'(data_o[DW-1:0]), 64'd0);
        drive(1'b0, 32'h0);
        step();
        rst_n   = 1'b1;
        ready_i = 1'b1;
        step();
        chk_bubble("arst.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
